// File: rtl/riscv_pkg.sv
// Shared register-file types for the writeback path: address/data widths and
// the {wa, wd} writeback entry carried through the long-result queue.
package riscv_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;
  localparam int NREG   = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [XLEN-1:0]   wd;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; the head entry is visible
// combinationally so the arbiter can write and pop it in the same cycle.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  wb_entry_t         mem_q [QDEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  assign full_o  = (count_q == CW'(QDEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_i && !pop_i)      count_d = count_q + CW'(1);
    else if (!push_i && pop_i) count_d = count_q - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count and pointers alone
  // define which entries are valid, so clearing the array adds nothing.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/reg_wb_scheduler.sv
// Register-file write-port arbiter (pipeline first, queued long results second)
// plus the pending scoreboard that stalls RAW/WAW hazards on long results.
module reg_wb_scheduler
  import riscv_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_wa,
  input  logic [XLEN-1:0]   pipe_wd,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] lu_wa,
  input  logic [XLEN-1:0]   lu_wd,
  input  logic              issue_valid,
  input  logic              issue_long,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic              issue_use1,
  input  logic              issue_use2,
  output logic              stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [XLEN-1:0]   rf_wd
);

  logic            pipe_eff;
  logic            q_push, q_pop, q_full, q_empty;
  wb_entry_t       q_in, q_head;
  logic            issue_fire;
  logic [NREG-1:0] pend_q, pend_d;

  assign pipe_eff = pipe_we && (pipe_wa != '0);
  assign lu_ready = !q_full;
  // Writes to x0 complete the handshake but never occupy the queue.
  assign q_push   = lu_valid && !q_full && (lu_wa != '0);
  assign q_pop    = !pipe_eff && !q_empty;
  assign q_in     = '{wa: lu_wa, wd: lu_wd};

  wb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (q_push),
    .push_data_i (q_in),
    .pop_i       (q_pop),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    if (pipe_eff) begin
      rf_we = 1'b1;
      rf_wa = pipe_wa;
      rf_wd = pipe_wd;
    end else if (q_pop) begin
      rf_we = 1'b1;
      rf_wa = q_head.wa;
      rf_wd = q_head.wd;
    end
  end

  // Destination pending covers both long and short issue (WAW).
  assign stall = issue_valid && ((issue_use1 && pend_q[issue_rs1]) ||
                                 (issue_use2 && pend_q[issue_rs2]) ||
                                 pend_q[issue_rd]);
  assign issue_fire = issue_valid && !stall;

  always_comb begin
    pend_d = pend_q;
    if (q_pop) pend_d[q_head.wa] = 1'b0;
    if (issue_fire && issue_long && (issue_rd != '0)) pend_d[issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Directed bench for reg_wb_scheduler: a per-cycle vector table plus hand
// sequences for reset while the queue is full.
module tb_reg_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_wa;
  logic [31:0] lu_wd;
  logic        issue_valid, issue_long;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_use1, issue_use2;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_wb_scheduler #(.QDEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_we     (pipe_we),
    .pipe_wa     (pipe_wa),
    .pipe_wd     (pipe_wd),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_wa       (lu_wa),
    .lu_wd       (lu_wd),
    .issue_valid (issue_valid),
    .issue_long  (issue_long),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_use1  (issue_use1),
    .issue_use2  (issue_use2),
    .stall       (stall),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd)
  );

  typedef struct {
    logic        pw;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        iv, il;
    logic [4:0]  rd, r1, r2;
    logic        u1, u2;
    logic        e_rdy, e_stall, e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
  } vec_t;

  function automatic vec_t mk(
    logic pw, logic [4:0] pa, logic [31:0] pd,
    logic lv, logic [4:0] la, logic [31:0] ld,
    logic iv, logic il, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2,
    logic u1, logic u2,
    logic e_rdy, logic e_stall, logic e_we, logic [4:0] e_wa, logic [31:0] e_wd);
    vec_t v;
    v.pw = pw; v.pa = pa; v.pd = pd;
    v.lv = lv; v.la = la; v.ld = ld;
    v.iv = iv; v.il = il; v.rd = rd; v.r1 = r1; v.r2 = r2;
    v.u1 = u1; v.u2 = u2;
    v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_we = e_we;
    v.e_wa = e_wa; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    pipe_we = v.pw; pipe_wa = v.pa; pipe_wd = v.pd;
    lu_valid = v.lv; lu_wa = v.la; lu_wd = v.ld;
    issue_valid = v.iv; issue_long = v.il; issue_rd = v.rd;
    issue_rs1 = v.r1; issue_rs2 = v.r2; issue_use1 = v.u1; issue_use2 = v.u2;
  endtask

  // Drive on the falling edge, compare 1 ns later; the rising edge commits.
  task automatic step(string tag, vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check({tag, " lu_ready"}, 32'(lu_ready), 32'(v.e_rdy));
    check({tag, " stall"},    32'(stall),    32'(v.e_stall));
    check({tag, " rf_we"},    32'(rf_we),    32'(v.e_we));
    check({tag, " rf_wa"},    32'(rf_wa),    32'(v.e_wa));
    check({tag, " rf_wd"},    rf_wd,         v.e_wd);
  endtask

  vec_t tbl [$];
  vec_t hv;

  initial begin
    //           pw pa  pd     lv la  ld            iv il rd  r1  r2  u1 u2  rdy st we wa  wd
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           0, 0, 0,  0,  0,  0, 0,  1, 0, 0, 0, 0));            // idle after reset
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           1, 0, 1,  2,  31, 1, 1,  1, 0, 0, 0, 0));            // nothing pending
    tbl.push_back(mk(0, 0, 0,     1, 5, 32'hDEADBEEF, 0, 0, 0, 0,  0,  0, 0,  1, 0, 0, 0, 0));            // push x5, no bypass
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           0, 0, 0,  0,  0,  0, 0,  1, 0, 1, 5, 32'hDEADBEEF)); // x5 written
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           0, 0, 0,  0,  0,  0, 0,  1, 0, 0, 0, 0));            // queue empty
    tbl.push_back(mk(1, 3, 32'h11, 1, 7, 32'h22,     0, 0, 0,  0,  0,  0, 0,  1, 0, 1, 3, 32'h11));       // pipe wins
    tbl.push_back(mk(1, 3, 32'h11, 1, 8, 32'h33,     0, 0, 0,  0,  0,  0, 0,  1, 0, 1, 3, 32'h11));
    tbl.push_back(mk(1, 3, 32'h11, 0, 0, 0,          0, 0, 0,  0,  0,  0, 0,  0, 0, 1, 3, 32'h11));       // full
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           0, 0, 0,  0,  0,  0, 0,  0, 0, 1, 7, 32'h22));       // pop keeps ready low
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           0, 0, 0,  0,  0,  0, 0,  1, 0, 1, 8, 32'h33));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           0, 0, 0,  0,  0,  0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           1, 1, 9,  0,  0,  0, 0,  1, 0, 0, 0, 0));            // long rd=x9 fires
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           1, 0, 10, 9,  0,  1, 0,  1, 1, 0, 0, 0));            // RAW stall
    tbl.push_back(mk(0, 0, 0,     1, 9, 32'h99,      1, 0, 10, 9,  0,  1, 0,  1, 1, 0, 0, 0));            // x9 result arrives
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           1, 0, 10, 9,  0,  1, 0,  1, 1, 1, 9, 32'h99));       // write cycle still stalls
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           1, 0, 10, 9,  0,  1, 0,  1, 0, 0, 0, 0));            // released
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           1, 1, 9,  0,  0,  0, 0,  1, 0, 0, 0, 0));            // long x9 again
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           1, 0, 9,  0,  0,  0, 0,  1, 1, 0, 0, 0));            // WAW short
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           1, 1, 9,  0,  0,  0, 0,  1, 1, 0, 0, 0));            // WAW long
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           1, 0, 11, 0,  9,  0, 1,  1, 1, 0, 0, 0));            // RAW via rs2
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           1, 0, 12, 9,  9,  0, 0,  1, 0, 0, 0, 0));            // unused sources ignored
    tbl.push_back(mk(1, 0, 32'h77, 0, 0, 0,          0, 0, 0,  0,  0,  0, 0,  1, 0, 0, 0, 0));            // pipe to x0 ignored
    tbl.push_back(mk(0, 0, 0,     1, 0, 32'h55,      0, 0, 0,  0,  0,  0, 0,  1, 0, 0, 0, 0));            // lu to x0 handshakes
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           0, 0, 0,  0,  0,  0, 0,  1, 0, 0, 0, 0));            // x0 was dropped
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           1, 1, 0,  0,  0,  0, 0,  1, 0, 0, 0, 0));            // long to x0
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,           1, 0, 0,  0,  0,  1, 1,  1, 0, 0, 0, 0));            // pend[0] stays 0

    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) step($sformatf("v%0d", i), tbl[i]);

    // Fill the queue behind a busy pipe, then reset with x9 still pending.
    step("fill0", mk(1, 4, 32'h1, 1, 12, 32'hA, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4, 32'h1));
    step("fill1", mk(1, 4, 32'h1, 1, 13, 32'hB, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4, 32'h1));
    hv = mk(1, 4, 32'h1, 0, 0, 0, 1, 0, 14, 9, 0, 1, 0, 0, 1, 1, 4, 32'h1);
    @(negedge clk);
    drive(hv);
    rst = 1'b1;
    #1;
    check("rst_full lu_ready", 32'(lu_ready), 32'(hv.e_rdy));
    check("rst_full stall",    32'(stall),    32'(hv.e_stall));
    @(negedge clk);
    rst = 1'b0;
    step("post_rst0", mk(0, 0, 0, 0, 0, 0, 1, 0, 14, 9, 9, 1, 1, 1, 0, 0, 0, 0));
    step("post_rst1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
